// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between the interconnect/master side and the SRAM responder.
// The master modport also drives hready, which the interconnect's read-data mux normally produces.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with programmable wait states,
// byte/halfword/word writes and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input logic             hclk,
  input logic             hreset,
  ahb_sram_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [1:0]    size_q;
  logic          load;
  logic          accept;
  logic          illegal;
  logic          done;
  logic          can_accept;
  logic [3:0]    byte_en;
  logic [31:0]   mem [MEM_DEPTH];

  logic unused_htrans;
  assign unused_htrans = bus.htrans[0];

  assign accept     = bus.hsel & bus.hready & bus.htrans[1];
  assign done       = (state == ACCESS) && (wcnt == 4'd0);
  // A new address phase can only be taken in cycles where this slave shows ready.
  assign can_accept = (state == IDLE) || (state == ERR2) || done;

  always_comb begin
    illegal = 1'b0;
    if (bus.hsize[2] || (bus.hsize[1:0] == 2'b11)) illegal = 1'b1;
    if ((bus.hsize == 3'b001) && bus.haddr[0]) illegal = 1'b1;
    if ((bus.hsize == 3'b010) && (bus.haddr[1:0] != 2'b00)) illegal = 1'b1;
    if (bus.haddr[31:AW+2] != '0) illegal = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    load      = 1'b0;
    if (can_accept) begin
      state_nxt = IDLE;
      if (accept) begin
        load      = 1'b1;
        state_nxt = illegal ? ERR1 : ACCESS;
        wcnt_nxt  = 4'(WAIT_STATES);
      end
    end else if (state == ACCESS) begin
      wcnt_nxt = wcnt - 4'd1;
    end else if (state == ERR1) begin
      state_nxt = ERR2;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (load) begin
        addr_q  <= bus.haddr[AW+1:0];
        write_q <= bus.hwrite;
        size_q  <= bus.hsize[1:0];
      end
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    unique case (size_q)
      2'b00:   byte_en = 4'b0001 << addr_q[1:0];
      2'b01:   byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory is deliberately left out of reset; a reset only suppresses the pending commit.
  always_ff @(posedge hclk) begin
    if (!hreset && done && write_q) begin
      for (int n = 0; n < 4; n++) begin
        if (byte_en[n]) mem[addr_q[AW+1:2]][8*n +: 8] <= bus.hwdata[8*n +: 8];
      end
    end
  end

  assign bus.hreadyout = can_accept;
  assign bus.hresp     = (state == ERR1) || (state == ERR2);
  assign bus.hrdata    = (done && !write_q) ? mem[addr_q[AW+1:2]] : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three responders (0, 1 and 3 wait states) behind a shared
// master, checked against a word-array reference model of the SRAM and bus timing.
module tb_ahb_sram_slave;
  localparam int WS0 = 0;
  localparam int WS1 = 1;
  localparam int WS2 = 3;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel_m = 1'b0;
  logic [31:0] haddr_m = '0;
  logic [1:0]  htrans_m = 2'b00;
  logic        hwrite_m = 1'b0;
  logic [2:0]  hsize_m = 3'b010;
  logic [31:0] hwdata_m = '0;
  logic        block_ready = 1'b0;
  int          target = 1;

  logic        cur_ready, cur_resp, hready_m;
  logic [31:0] cur_rdata;

  int total = 0;
  int bad = 0;

  logic [31:0] model_mem [3][256];

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();
  ahb_sram_slave_if bus2 ();

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(WS0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0.slave));
  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(WS1)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1.slave));
  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(WS2)) dut2 (.hclk(hclk), .hreset(hreset), .bus(bus2.slave));

  always #5 hclk = ~hclk;

  // Read-data mux: the selected responder's ready/response/data go back to the master.
  assign cur_ready = (target == 0) ? bus0.hreadyout : (target == 1) ? bus1.hreadyout : bus2.hreadyout;
  assign cur_resp  = (target == 0) ? bus0.hresp     : (target == 1) ? bus1.hresp     : bus2.hresp;
  assign cur_rdata = (target == 0) ? bus0.hrdata    : (target == 1) ? bus1.hrdata    : bus2.hrdata;
  assign hready_m  = cur_ready & ~block_ready;

  assign bus0.hsel = hsel_m && (target == 0);
  assign bus1.hsel = hsel_m && (target == 1);
  assign bus2.hsel = hsel_m && (target == 2);
  assign {bus0.haddr, bus1.haddr, bus2.haddr}    = {3{haddr_m}};
  assign {bus0.htrans, bus1.htrans, bus2.htrans} = {3{htrans_m}};
  assign {bus0.hwrite, bus1.hwrite, bus2.hwrite} = {3{hwrite_m}};
  assign {bus0.hsize, bus1.hsize, bus2.hsize}    = {3{hsize_m}};
  assign {bus0.hwdata, bus1.hwdata, bus2.hwdata} = {3{hwdata_m}};
  assign {bus0.hready, bus1.hready, bus2.hready} = {3{hready_m}};

  function automatic int ws_of(input int t);
    return (t == 0) ? WS0 : (t == 1) ? WS1 : WS2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (t=%0t target=%0d)", tag, got, exp, $time, target);
    end
  endtask

  task automatic drive_idle();
    hsel_m   = 1'b0;
    htrans_m = 2'b00;
  endtask

  // One non-pipelined-from-the-master's-view transfer, started at a falling edge and
  // returning at the falling edge of its final data-phase cycle, so the next call overlaps.
  task automatic applyStimulus(input logic wr, input logic [2:0] sz, input logic [31:0] ad,
                               input logic [31:0] wd);
    logic        legal;
    logic        first_resp;
    int          idx;
    int          nb;
    int          lane;
    int          waits;
    logic [31:0] exp_rd;
    legal  = (sz <= 3'd2) && ((ad % (32'd1 << sz)) == 32'd0) && (ad < 32'd1024);
    idx    = legal ? int'(ad >> 2) : 0;
    exp_rd = model_mem[target][idx];
    hsel_m   = 1'b1;
    htrans_m = 2'b10;
    hwrite_m = wr;
    hsize_m  = sz;
    haddr_m  = ad;
    @(negedge hclk);
    drive_idle();
    hwdata_m   = wd;
    first_resp = cur_resp;
    waits      = 0;
    while (cur_ready !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge hclk);
    end
    if (legal) begin
      checkOutput("wait_count", 32'(waits), 32'(ws_of(target)));
      checkOutput("okay_resp", {31'd0, cur_resp}, 32'd0);
      if (!wr) begin
        checkOutput("read_data", cur_rdata, exp_rd);
      end else begin
        nb = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
        for (int b = 0; b < nb; b++) begin
          lane = int'(ad % 4) + b;
          model_mem[target][idx][lane*8 +: 8] = wd[lane*8 +: 8];
        end
      end
    end else begin
      checkOutput("err1_resp", {31'd0, first_resp}, 32'd1);
      checkOutput("err_waits", 32'(waits), 32'd1);
      checkOutput("err2_resp", {31'd0, cur_resp}, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checkOutput("rst_ready0", {31'd0, bus0.hreadyout}, 32'd1);
    checkOutput("rst_ready1", {31'd0, bus1.hreadyout}, 32'd1);
    checkOutput("rst_ready2", {31'd0, bus2.hreadyout}, 32'd1);
    checkOutput("rst_resp0", {31'd0, bus0.hresp}, 32'd0);
    checkOutput("rst_resp1", {31'd0, bus1.hresp}, 32'd0);
    checkOutput("rst_resp2", {31'd0, bus2.hresp}, 32'd0);
    checkOutput("rst_rdata0", bus0.hrdata, 32'd0);
    checkOutput("rst_rdata1", bus1.hrdata, 32'd0);
    checkOutput("rst_rdata2", bus2.hrdata, 32'd0);
    hreset = 1'b0;

    // Give every responder known contents in the first 64 words.
    for (int t = 0; t < 3; t++) begin
      target = t;
      for (int w = 0; w < 64; w++) applyStimulus(1'b1, 3'd2, 32'(w * 4), $urandom);
    end

    target = 1;
    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
    checkOutput("word_readback", cur_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'd2, 32'h20, 32'h00000000);
    applyStimulus(1'b1, 3'd0, 32'h21, 32'h0000AB00);
    applyStimulus(1'b1, 3'd1, 32'h22, 32'h12340000);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0);
    checkOutput("lane_merge", cur_rdata, 32'h1234AB00);
    applyStimulus(1'b0, 3'd2, 32'h06, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'h06, 32'hFFFFFFFF);
    applyStimulus(1'b0, 3'd2, 32'h400, 32'h0);
    applyStimulus(1'b0, 3'd3, 32'h20, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h04, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0);
    checkOutput("after_errors", cur_rdata, 32'h1234AB00);

    // An address phase seen while global hready is low must be ignored.
    @(negedge hclk);
    block_ready = 1'b1;
    hsel_m = 1'b1; htrans_m = 2'b10; hwrite_m = 1'b0; hsize_m = 3'd2; haddr_m = 32'h10;
    @(negedge hclk);
    checkOutput("hready_low_ready", {31'd0, bus1.hreadyout}, 32'd1);
    checkOutput("hready_low_resp", {31'd0, bus1.hresp}, 32'd0);
    drive_idle();
    block_ready = 1'b0;
    @(negedge hclk);

    // Zero-wait responder: 4 burst writes then 4 pipelined reads.
    target = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        checkOutput("burst_ready", {31'd0, cur_ready}, 32'd1);
        checkOutput("burst_resp", {31'd0, cur_resp}, 32'd0);
        if (c >= 5) checkOutput("burst_rdata", cur_rdata, 32'(c - 4));
      end
      hwdata_m = (c >= 1 && c <= 4) ? 32'(c) : 32'd0;
      if (c < 8) begin
        hsel_m   = 1'b1;
        htrans_m = (c == 0 || c == 4) ? 2'b10 : 2'b11;
        hwrite_m = (c < 4);
        hsize_m  = 3'd2;
        haddr_m  = 32'((c % 4) * 4);
        if (c < 4) model_mem[0][c] = 32'(c + 1);
      end else begin
        drive_idle();
      end
      @(negedge hclk);
    end

    // Reset lands in the second wait cycle of a write; the write must be lost.
    target = 2;
    hsel_m = 1'b1; htrans_m = 2'b10; hwrite_m = 1'b1; hsize_m = 3'd2; haddr_m = 32'h30;
    @(negedge hclk);
    drive_idle();
    hwdata_m = 32'h55AA55AA;
    checkOutput("mid_wait1_ready", {31'd0, cur_ready}, 32'd0);
    @(negedge hclk);
    checkOutput("mid_wait2_ready", {31'd0, cur_ready}, 32'd0);
    hreset = 1'b1;
    @(negedge hclk);
    checkOutput("mid_rst_ready", {31'd0, cur_ready}, 32'd1);
    checkOutput("mid_rst_resp", {31'd0, cur_resp}, 32'd0);
    checkOutput("mid_rst_rdata", cur_rdata, 32'd0);
    hreset = 1'b0;
    applyStimulus(1'b0, 3'd2, 32'h30, 32'h0);

    // Random mix of legal and illegal transfers with occasional idle gaps.
    for (int t = 0; t < 3; t++) begin
      target = t;
      for (int n = 0; n < 150; n++) begin
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        ad = ($urandom_range(0, 19) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                          : 32'($urandom_range(0, 255));
        applyStimulus(1'($urandom_range(0, 1)), sz, ad, $urandom);
        if ($urandom_range(0, 3) == 0) @(negedge hclk);
      end
    end

    @(negedge hclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
